// File: rtl/sent_pkg.sv
// Shared definitions for the SENT transmit pulse generator: FSM state
// encoding, symbol timing constants and small length/clamp helpers.
package sent_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_STATUS = 3'd2,
    ST_DATA   = 3'd3,
    ST_CRC    = 3'd4,
    ST_PAUSE  = 3'd5,
    ST_END    = 3'd6
  } sent_state_e;

  localparam logic [11:0] SYNC_TICKS    = 12'd56;
  localparam logic [11:0] NIBBLE_OFFSET = 12'd12;
  localparam logic [11:0] LOW_TICKS     = 12'd5;
  localparam logic [11:0] MIN_PAUSE     = 12'd12;
  localparam logic [2:0]  MAX_DATA_NB   = 3'd6;

  // Data nibble count: 0 still sends one nibble, anything above six sends six.
  function automatic logic [2:0] clamp_data_nb(input logic [2:0] n);
    if (n == 3'd0) return 3'd1;
    if (n > MAX_DATA_NB) return MAX_DATA_NB;
    return n;
  endfunction

  // Nibble-carrying symbols are 12 ticks plus the nibble value.
  function automatic logic [11:0] nibble_ticks(input logic [3:0] nb);
    return NIBBLE_OFFSET + {8'd0, nb};
  endfunction

  // A pause pulse is never shorter than the minimum symbol length.
  function automatic logic [11:0] clamp_pause(input logic [11:0] p);
    return (p < MIN_PAUSE) ? MIN_PAUSE : p;
  endfunction

endpackage

// File: rtl/sent_tick_gen.sv
// SENT tick divider: emits one tick strobe every div+1 clocks while enabled.
// The divisor is latched on restart so a frame keeps one tick length.
module sent_tick_gen (
  input  logic        clk_rx,
  input  logic        reset_n_rx,
  input  logic        enable_i,
  input  logic        restart_i,
  input  logic [10:0] div_i,
  output logic        tick_o
);

  logic [10:0] cnt_q, cnt_d;
  logic [10:0] div_q;

  // Next divider count: restart wins, otherwise count 0..div_q and wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = (cnt_q == div_q) ? '0 : cnt_q + 11'd1;
    end
  end

  // Divider count and latched divisor registers.
  always_ff @(posedge clk_rx or negedge reset_n_rx) begin
    if (!reset_n_rx) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (restart_i) div_q <= div_i;
    end
  end

  // Not gated by restart: the frame FSM needs the tick in the same cycle
  // that a back-to-back accept restarts the divider.
  assign tick_o = enable_i && (cnt_q == div_q);

endmodule

// File: rtl/sent_tx_pulse_gen.sv
// SENT transmit pulse generator. Produces SYNC, STATUS, DATA (x N), CRC,
// optional PAUSE and an END low pulse on an idle-high line.
//
// Handshake: a frame is taken on every rising clk_rx edge where
// frame_valid_i && frame_ready_o. frame_ready_o is high in IDLE and in the
// final clock of the last symbol before END; an accept there chains the
// next SYNC with no END and no gap clock. frame_valid_i outside that window
// is ignored and all frame fields (tick_div_i included) are held from the
// accepting edge until the frame ends.
module sent_tx_pulse_gen
  import sent_pkg::*;
(
  input  logic        clk_rx,
  input  logic        reset_n_rx,
  input  logic [10:0] tick_div_i,
  input  logic        frame_valid_i,
  output logic        frame_ready_o,
  input  logic [3:0]  status_nb_i,
  input  logic [23:0] data_nibbles_i,
  input  logic [2:0]  num_data_nb_i,
  input  logic [3:0]  crc_nb_i,
  input  logic        pause_en_i,
  input  logic [11:0] pause_ticks_i,
  output logic        data_pulse_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic [2:0]  dbg_state_o
);

  sent_state_e state_q, state_d;
  logic [11:0] tick_cnt_q, tick_cnt_d;
  logic        line_q, line_d;
  logic [3:0]  status_q, status_d;
  logic [3:0]  crc_q, crc_d;
  logic [23:0] data_q, data_d;
  logic [2:0]  nb_left_q, nb_left_d;
  logic        pause_en_q, pause_en_d;
  logic [11:0] pause_len_q, pause_len_d;

  logic        tick;
  logic        busy;
  logic        accept;
  logic        sym_end;
  logic        last_sym;
  logic        window;
  logic [11:0] sym_len;

  assign busy     = (state_q != ST_IDLE);
  assign sym_end  = (tick_cnt_q == sym_len - 12'd1);
  assign last_sym = ((state_q == ST_CRC) && !pause_en_q) || (state_q == ST_PAUSE);
  assign window   = last_sym && tick && sym_end;
  assign accept   = frame_valid_i && frame_ready_o;

  assign frame_ready_o = !busy || window;
  assign frame_done_o  = window;
  assign busy_o        = busy;
  assign data_pulse_o  = line_q;
  assign dbg_state_o   = state_q;

  sent_tick_gen u_tick_gen (
    .clk_rx     (clk_rx),
    .reset_n_rx (reset_n_rx),
    .enable_i   (busy),
    .restart_i  (accept),
    .div_i      (tick_div_i),
    .tick_o     (tick)
  );

  // Length in ticks of the symbol currently on the line.
  always_comb begin
    sym_len = SYNC_TICKS;
    case (state_q)
      ST_SYNC:   sym_len = SYNC_TICKS;
      ST_STATUS: sym_len = nibble_ticks(status_q);
      ST_DATA:   sym_len = nibble_ticks(data_q[23:20]);
      ST_CRC:    sym_len = nibble_ticks(crc_q);
      ST_PAUSE:  sym_len = pause_len_q;
      ST_END:    sym_len = LOW_TICKS;
      default:   sym_len = SYNC_TICKS;
    endcase
  end

  // Frame sequencing: capture on accept, advance ticks, move to the next
  // symbol (pulling the line low) when the current one runs out.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    line_d      = line_q;
    status_d    = status_q;
    crc_d       = crc_q;
    data_d      = data_q;
    nb_left_d   = nb_left_q;
    pause_en_d  = pause_en_q;
    pause_len_d = pause_len_q;
    if (accept) begin
      state_d     = ST_SYNC;
      tick_cnt_d  = '0;
      line_d      = 1'b0;
      status_d    = status_nb_i;
      crc_d       = crc_nb_i;
      data_d      = data_nibbles_i;
      nb_left_d   = clamp_data_nb(num_data_nb_i);
      pause_en_d  = pause_en_i;
      pause_len_d = clamp_pause(pause_ticks_i);
    end else if (busy && tick) begin
      if (sym_end) begin
        tick_cnt_d = '0;
        line_d     = 1'b0;
        case (state_q)
          ST_SYNC:   state_d = ST_STATUS;
          ST_STATUS: state_d = ST_DATA;
          ST_DATA: begin
            if (nb_left_q == 3'd1) begin
              state_d = ST_CRC;
            end else begin
              nb_left_d = nb_left_q - 3'd1;
              data_d    = {data_q[19:0], 4'h0};
            end
          end
          ST_CRC:    state_d = pause_en_q ? ST_PAUSE : ST_END;
          ST_PAUSE:  state_d = ST_END;
          ST_END: begin
            state_d = ST_IDLE;
            line_d  = 1'b1;
          end
          default: begin
            state_d = ST_IDLE;
            line_d  = 1'b1;
          end
        endcase
      end else begin
        tick_cnt_d = tick_cnt_q + 12'd1;
        if (tick_cnt_q == LOW_TICKS - 12'd1) line_d = 1'b1;
      end
    end
  end

  // Frame state, counters, line and captured fields.
  always_ff @(posedge clk_rx or negedge reset_n_rx) begin
    if (!reset_n_rx) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      line_q      <= 1'b1;
      status_q    <= '0;
      crc_q       <= '0;
      data_q      <= '0;
      nb_left_q   <= '0;
      pause_en_q  <= 1'b0;
      pause_len_q <= '0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      line_q      <= line_d;
      status_q    <= status_d;
      crc_q       <= crc_d;
      data_q      <= data_d;
      nb_left_q   <= nb_left_d;
      pause_en_q  <= pause_en_d;
      pause_len_q <= pause_len_d;
    end
  end

endmodule

// File: tb/tb_sent_tx_pulse_gen.sv
// Bench for sent_tx_pulse_gen: table of frame vectors with hand-computed
// symbol counts, spans and low widths, plus directed back-to-back,
// reset-abort and tick-divider-change sequences.
module tb_sent_tx_pulse_gen;

  logic        clk_rx = 1'b0;
  logic        reset_n_rx = 1'b1;
  logic [10:0] tick_div_i = '0;
  logic        frame_valid_i = 1'b0;
  logic        frame_ready_o;
  logic [3:0]  status_nb_i = '0;
  logic [23:0] data_nibbles_i = '0;
  logic [2:0]  num_data_nb_i = '0;
  logic [3:0]  crc_nb_i = '0;
  logic        pause_en_i = 1'b0;
  logic [11:0] pause_ticks_i = '0;
  logic        data_pulse_o;
  logic        busy_o;
  logic        frame_done_o;
  logic [2:0]  dbg_state_o;

  typedef struct {
    logic [10:0] div;
    logic [3:0]  st;
    logic [23:0] data;
    logic [2:0]  n;
    logic [3:0]  crc;
    logic        pen;
    logic [11:0] pt;
    int          falls;
    int          span;
    int          low;
  } vec_t;

  vec_t vecs[9];
  vec_t v_slow;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int fall_q[$];
  int rise_q[$];
  logic [11:0] exp_q[$];
  bit prev_line = 1'b1;

  sent_tx_pulse_gen dut (
    .clk_rx         (clk_rx),
    .reset_n_rx     (reset_n_rx),
    .tick_div_i     (tick_div_i),
    .frame_valid_i  (frame_valid_i),
    .frame_ready_o  (frame_ready_o),
    .status_nb_i    (status_nb_i),
    .data_nibbles_i (data_nibbles_i),
    .num_data_nb_i  (num_data_nb_i),
    .crc_nb_i       (crc_nb_i),
    .pause_en_i     (pause_en_i),
    .pause_ticks_i  (pause_ticks_i),
    .data_pulse_o   (data_pulse_o),
    .busy_o         (busy_o),
    .frame_done_o   (frame_done_o),
    .dbg_state_o    (dbg_state_o)
  );

  // Clock and cycle counter
  always #5 clk_rx = ~clk_rx;
  always @(posedge clk_rx) cyc++;

  // Line monitor, sampled on the falling edge
  always @(negedge clk_rx) begin
    if (prev_line && !data_pulse_o) fall_q.push_back(cyc);
    if (!prev_line && data_pulse_o) rise_q.push_back(cyc);
    if (frame_done_o) done_cnt++;
    prev_line = data_pulse_o;
  end

  // Watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_frame(input vec_t v);
    fall_q.delete();
    rise_q.delete();
    done_cnt       = 0;
    tick_div_i     = v.div;
    status_nb_i    = v.st;
    data_nibbles_i = v.data;
    num_data_nb_i  = v.n;
    crc_nb_i       = v.crc;
    pause_en_i     = v.pen;
    pause_ticks_i  = v.pt;
    frame_valid_i  = 1'b1;
    @(posedge clk_rx); #1;
    frame_valid_i  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_rx);
      if (!busy_o) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk_rx);
  endtask

  task automatic check_frame(input vec_t v, input string nm);
    bit ok;
    wait_idle(20000, ok);
    check({nm, "_idle"}, int'(ok), 1);
    check({nm, "_falls"}, fall_q.size(), v.falls);
    check({nm, "_done"}, done_cnt, 1);
    if (fall_q.size() > 0 && rise_q.size() > 0) begin
      check({nm, "_span"}, fall_q[$] - fall_q[0], v.span);
      check({nm, "_sync_low"}, rise_q[0] - fall_q[0], v.low);
      check({nm, "_end_low"}, rise_q[$] - fall_q[$], v.low);
    end
    check({nm, "_line_idle"}, int'(data_pulse_o), 1);
    check({nm, "_ready_idle"}, int'(frame_ready_o), 1);
  endtask

  initial begin
    bit ok;
    int n0;

    //            div    st    data         n     crc   pen  pt      falls span  low
    vecs[0] = '{11'd2, 4'h5, 24'hABCDEF, 3'd6, 4'h3, 1'b0, 12'd0,    10, 705,  15};
    vecs[1] = '{11'd2, 4'h5, 24'hABCDEF, 3'd6, 4'h3, 1'b1, 12'd100,  11, 1005, 15};
    vecs[2] = '{11'd2, 4'h5, 24'hABCDEF, 3'd6, 4'h3, 1'b1, 12'd5,    11, 741,  15};
    vecs[3] = '{11'd2, 4'h5, 24'hABCDEF, 3'd0, 4'h3, 1'b0, 12'd0,    5,  330,  15};
    vecs[4] = '{11'd2, 4'h5, 24'hABCDEF, 3'd7, 4'h3, 1'b0, 12'd0,    10, 705,  15};
    vecs[5] = '{11'd0, 4'h0, 24'h000000, 3'd1, 4'hF, 1'b0, 12'd0,    5,  107,  5};
    vecs[6] = '{11'd5, 4'hF, 24'h123456, 3'd2, 4'h0, 1'b0, 12'd0,    6,  732,  30};
    vecs[7] = '{11'd0, 4'h0, 24'h000000, 3'd1, 4'h0, 1'b1, 12'd12,   6,  104,  5};
    vecs[8] = '{11'd0, 4'h0, 24'h000000, 3'd1, 4'h0, 1'b1, 12'd4095, 6,  4187, 5};
    v_slow  = '{11'd5, 4'h5, 24'hABCDEF, 3'd6, 4'h3, 1'b0, 12'd0,    10, 1410, 30};

    // Asynchronous reset values
    #1 reset_n_rx = 1'b0;
    #2;
    check("rst_line", int'(data_pulse_o), 1);
    check("rst_ready", int'(frame_ready_o), 1);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(frame_done_o), 0);
    check("rst_state", int'(dbg_state_o), 0);
    repeat (3) @(posedge clk_rx);
    #1 reset_n_rx = 1'b1;
    repeat (2) @(posedge clk_rx);
    #1;

    // Reference frame with per-symbol periods
    start_frame(vecs[0]);
    check("accept_line_low", int'(data_pulse_o), 0);
    check("accept_busy", int'(busy_o), 1);
    check_frame(vecs[0], "v0");
    exp_q = '{12'd168, 12'd51, 12'd66, 12'd69, 12'd72, 12'd75, 12'd78, 12'd81, 12'd45};
    for (int k = 0; k < 9; k++) begin
      if (fall_q.size() > k + 1) check("v0_period", fall_q[k+1] - fall_q[k], int'(exp_q[k]));
    end
    for (int k = 0; k + 1 < rise_q.size(); k++) begin
      check("v0_low", rise_q[k] - fall_q[k], 15);
    end

    // Remaining table vectors
    for (int i = 1; i < 9; i++) begin
      start_frame(vecs[i]);
      check_frame(vecs[i], $sformatf("v%0d", i));
    end

    // Back-to-back frames with valid held high
    fall_q.delete();
    rise_q.delete();
    done_cnt       = 0;
    tick_div_i     = 11'd2;
    status_nb_i    = 4'h5;
    data_nibbles_i = 24'hABC000;
    num_data_nb_i  = 3'd3;
    crc_nb_i       = 4'h3;
    pause_en_i     = 1'b0;
    frame_valid_i  = 1'b1;
    @(posedge clk_rx); #1;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_rx);
      if (frame_done_o) begin
        ok = 1'b1;
        break;
      end
    end
    check("b2b_first_done", int'(ok), 1);
    check("b2b_ready_window", int'(frame_ready_o), 1);
    @(posedge clk_rx); #1;
    frame_valid_i = 1'b0;
    wait_idle(5000, ok);
    check("b2b_idle", int'(ok), 1);
    check("b2b_falls", fall_q.size(), 13);
    check("b2b_done", done_cnt, 2);
    if (fall_q.size() >= 13) begin
      check("b2b_crc_to_sync", fall_q[6] - fall_q[5], 45);
      check("b2b_frame1", fall_q[6] - fall_q[0], 471);
      check("b2b_frame2", fall_q[12] - fall_q[6], 471);
    end

    // Reset during the third data nibble
    start_frame(vecs[0]);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_rx);
      if (fall_q.size() >= 5) begin
        ok = 1'b1;
        break;
      end
    end
    check("rstmid_reach_d3", int'(ok), 1);
    check("rstmid_line_low", int'(data_pulse_o), 0);
    #2 reset_n_rx = 1'b0;
    #1;
    check("rstmid_line", int'(data_pulse_o), 1);
    check("rstmid_busy", int'(busy_o), 0);
    check("rstmid_ready", int'(frame_ready_o), 1);
    check("rstmid_state", int'(dbg_state_o), 0);
    @(posedge clk_rx); #1;
    reset_n_rx = 1'b1;
    n0 = fall_q.size();
    repeat (30) @(negedge clk_rx);
    check("rstmid_no_end", fall_q.size(), n0);
    start_frame(vecs[0]);
    check_frame(vecs[0], "rstmid_new");
    if (fall_q.size() > 1) check("rstmid_sync", fall_q[1] - fall_q[0], 168);

    // Divider change mid-frame plus ignored request
    start_frame(vecs[0]);
    repeat (100) @(negedge clk_rx);
    check("divchg_ready_low", int'(frame_ready_o), 0);
    tick_div_i     = 11'd5;
    data_nibbles_i = 24'h111111;
    status_nb_i    = 4'h0;
    frame_valid_i  = 1'b1;
    repeat (3) @(posedge clk_rx);
    #1 frame_valid_i = 1'b0;
    check_frame(vecs[0], "divchg_cur");
    start_frame(v_slow);
    check_frame(v_slow, "divchg_next");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
